// File: rtl/matrix_transform.sv
// Sequencer between a point source and an external 2D matrix-multiply core: latches a request,
// collects the x'/y' result beats, narrows them and presents the point. Option: MATRIX_TRANSFORM_SAT_EN.
module matrix_transform #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic signed [DATA_WIDTH-1:0]   x_in,
  input  logic signed [DATA_WIDTH-1:0]   y_in,
  input  logic        [1:0]              transform_type,
  input  logic signed [DATA_WIDTH-1:0]   param1,
  input  logic signed [DATA_WIDTH-1:0]   param2,
  input  logic signed [2*DATA_WIDTH-1:0] matrix_result,
  input  logic                           matrix_valid,
  output logic signed [DATA_WIDTH-1:0]   x_out,
  output logic signed [DATA_WIDTH-1:0]   y_out,
  output logic        [2*DATA_WIDTH-1:0] combined_out,
  output logic                           transform_valid,
  output logic                           transform_done
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_X, WAIT_Y, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  x_lat_q, x_lat_d, y_lat_q, y_lat_d;
  logic [DATA_WIDTH-1:0]  param1_q, param1_d, param2_q, param2_d;
  logic [1:0]             type_q, type_d;
  logic [DATA_WIDTH-1:0]  pend_x_q, pend_x_d;
  logic [DATA_WIDTH-1:0]  x_out_q, x_out_d, y_out_q, y_out_d;
  logic                   valid_q, valid_d, done_q, done_d;

  function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [2*DATA_WIDTH-1:0] v);
`ifdef MATRIX_TRANSFORM_SAT_EN
    logic signed [2*DATA_WIDTH-1:0] max_v;
    logic signed [2*DATA_WIDTH-1:0] min_v;
    max_v = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    min_v = ~max_v;
    if (v > max_v)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (v < min_v) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                return v[DATA_WIDTH-1:0];
`else
    return v[DATA_WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    state_d  = state_q;
    x_lat_d  = x_lat_q;
    y_lat_d  = y_lat_q;
    param1_d = param1_q;
    param2_d = param2_q;
    type_d   = type_q;
    pend_x_d = pend_x_q;
    x_out_d  = x_out_q;
    y_out_d  = y_out_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_lat_d  = x_in;
          y_lat_d  = y_in;
          param1_d = param1;
          param2_d = param2;
          type_d   = transform_type;
          valid_d  = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (type_q == 2'b11) begin
          x_out_d = x_lat_q;
          y_out_d = y_lat_q;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT_X;
        end
      end
      WAIT_X: begin
        if (matrix_valid) begin
          pend_x_d = narrow(matrix_result);
          state_d  = WAIT_Y;
        end
      end
      WAIT_Y: begin
        // x' is held aside so both coordinates update on the same edge
        if (matrix_valid) begin
          x_out_d = pend_x_q;
          y_out_d = narrow(matrix_result);
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_lat_q  <= '0;
      y_lat_q  <= '0;
      param1_q <= '0;
      param2_q <= '0;
      type_q   <= '0;
      pend_x_q <= '0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_lat_q  <= x_lat_d;
      y_lat_q  <= y_lat_d;
      param1_q <= param1_d;
      param2_q <= param2_d;
      type_q   <= type_d;
      pend_x_q <= pend_x_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Parameters are latched for the core side of the request; nothing here consumes them.
  logic unused_sink;
  assign unused_sink = ^{param1_q, param2_q, matrix_result};

  assign x_out           = x_out_q;
  assign y_out           = y_out_q;
  assign combined_out    = {x_out_q, y_out_q};
  assign transform_valid = valid_q;
  assign transform_done  = done_q;

endmodule

// File: tb/tb_matrix_transform.sv
// Self-checking bench for matrix_transform: directed scenarios plus randomized transactions
// against a coordinate-level reference model.
module tb_matrix_transform;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x_in = '0, y_in = '0, param1 = '0, param2 = '0;
  logic [1:0]  transform_type = '0;
  logic [15:0] matrix_result = '0;
  logic        matrix_valid = 1'b0;
  logic [7:0]  x_out, y_out;
  logic [15:0] combined_out;
  logic        transform_valid, transform_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl_x = '0, mdl_y = '0;
  logic       mdl_valid = 1'b0;

  matrix_transform #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
    .transform_type(transform_type), .param1(param1), .param2(param2),
    .matrix_result(matrix_result), .matrix_valid(matrix_valid),
    .x_out(x_out), .y_out(y_out), .combined_out(combined_out),
    .transform_valid(transform_valid), .transform_done(transform_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Beat narrowing computed on integers rather than bit slices of the beat.
  function automatic logic [7:0] model_narrow(input logic [15:0] b);
    int v;
    int r;
    v = int'($signed(b));
`ifdef MATRIX_TRANSFORM_SAT_EN
    r = (v > 127) ? 127 : ((v < -128) ? -128 : v);
`else
    r = ((v % 256) + 256) % 256;
    if (r > 127) r = r - 256;
`endif
    return r[7:0];
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_x"}, {8'h00, x_out}, {8'h00, mdl_x});
    check({tag, "_y"}, {8'h00, y_out}, {8'h00, mdl_y});
    check({tag, "_comb"}, combined_out, {mdl_x, mdl_y});
    check({tag, "_valid"}, {15'h0, transform_valid}, {15'h0, mdl_valid});
  endtask

  task automatic run_txn(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [1:0] t, input logic [7:0] p1, input logic [7:0] p2,
                         input logic [15:0] b1, input logic [15:0] b2,
                         input int unsigned gap, input bit b2b, input bit junk_load,
                         input bit poke_start);
    @(negedge clk);
    start = 1'b1; x_in = x; y_in = y; transform_type = t; param1 = p1; param2 = p2;
    @(negedge clk);  // in LOAD
    start = 1'b0;
    x_in = 8'($urandom); y_in = 8'($urandom); param1 = 8'($urandom); param2 = 8'($urandom);
    transform_type = 2'($urandom);
    check({tag, "_valid_clr"}, {15'h0, transform_valid}, 16'h0);
    check({tag, "_done_load"}, {15'h0, transform_done}, 16'h0);
    mdl_valid = 1'b0;
    if (junk_load) begin
      matrix_valid = 1'b1; matrix_result = 16'hDEAD;
    end
    if (t == 2'b11) begin
      @(negedge clk);
      matrix_valid = 1'b0;
      mdl_x = x; mdl_y = y; mdl_valid = 1'b1;
      // done is high in the third cycle, counting the start cycle as the first
      check({tag, "_done"}, {15'h0, transform_done}, 16'h1);
      check_outputs(tag);
    end else begin
      @(negedge clk);  // in WAIT_X
      matrix_valid = 1'b0;
      if (poke_start) begin
        start = 1'b1; transform_type = 2'b11; x_in = 8'h5A; y_in = 8'hA5;
        @(negedge clk);
        start = 1'b0;
      end
      repeat (gap) @(negedge clk);
      check({tag, "_done_wait"}, {15'h0, transform_done}, 16'h0);
      matrix_valid = 1'b1; matrix_result = b1;
      @(negedge clk);
      check({tag, "_x_hold"}, {8'h00, x_out}, {8'h00, mdl_x});
      check({tag, "_done_beat1"}, {15'h0, transform_done}, 16'h0);
      if (b2b) begin
        matrix_result = b2;
      end else begin
        matrix_valid = 1'b0; matrix_result = 16'hBEEF;
        @(negedge clk);
        matrix_valid = 1'b1; matrix_result = b2;
      end
      @(negedge clk);
      matrix_valid = 1'b0;
      mdl_x = model_narrow(b1); mdl_y = model_narrow(b2); mdl_valid = 1'b1;
      check({tag, "_done"}, {15'h0, transform_done}, 16'h1);
      check_outputs(tag);
    end
    @(negedge clk);
    check({tag, "_done_once"}, {15'h0, transform_done}, 16'h0);
    check_outputs({tag, "_held"});
  endtask

  initial begin
    #2;
    check_outputs("reset");
    check("reset_done", {15'h0, transform_done}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("rotate", 8'd10, 8'd0, 2'b00, 8'd45, 8'd0, 16'h0007, 16'h0007, 1, 0, 0, 0);
    check("rotate_comb_const", combined_out, 16'h0707);
    run_txn("scale", 8'd5, 8'd5, 2'b01, 8'd2, 8'd2, 16'h000A, 16'h000A, 0, 1, 0, 0);
    run_txn("translate", 8'd3, 8'd4, 2'b10, 8'd5, 8'd10, 16'h0008, 16'h000E, 2, 0, 1, 0);
    check("translate_comb_const", combined_out, 16'h080E);
    run_txn("identity", 8'hFD, 8'd12, 2'b11, 8'd0, 8'd0, 16'h0, 16'h0, 0, 0, 0, 0);
    check("identity_x_const", {8'h00, x_out}, 16'h00FD);

    // Beat while idle must be discarded
    @(negedge clk);
    matrix_valid = 1'b1; matrix_result = 16'h55AA;
    @(negedge clk);
    matrix_valid = 1'b0;
    check_outputs("idle_beat");
    run_txn("after_idle_beat", 8'd9, 8'd9, 2'b00, 8'd1, 8'd1, 16'h0001, 16'h0002, 0, 1, 0, 0);

    run_txn("restart_ignored", 8'd7, 8'd8, 2'b01, 8'd3, 8'd3, 16'h0015, 16'h0018, 1, 0, 0, 1);

    // Reset while waiting for y'
    @(negedge clk);
    start = 1'b1; x_in = 8'd1; y_in = 8'd2; transform_type = 2'b00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    matrix_valid = 1'b1; matrix_result = 16'h0011;
    @(negedge clk);
    matrix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    mdl_x = '0; mdl_y = '0; mdl_valid = 1'b0;
    check_outputs("mid_reset");
    check("mid_reset_done", {15'h0, transform_done}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("post_reset", 8'd2, 8'd3, 2'b10, 8'd1, 8'd1, 16'h0003, 16'h0004, 0, 1, 0, 0);

    run_txn("narrow", 8'd0, 8'd0, 2'b01, 8'd0, 8'd0, 16'h00C8, 16'hFF00, 0, 1, 0, 0);
`ifdef MATRIX_TRANSFORM_SAT_EN
    check("narrow_const", combined_out, 16'h7F80);
`else
    check("narrow_const", combined_out, 16'hC800);
`endif

    for (int i = 0; i < 24; i++) begin
      run_txn($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
              8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
